// File: rtl/exec_sequencer.sv
// ---------------------------------------------------------------------------
// exec_sequencer
//
// Fetch/decode/issue controller for the single-cycle execution unit. Owns the
// program counter, fetches 32-bit instruction words over a req/ack handshake,
// registers the decoded fields, pulses exec_en for one cycle and then loads
// the PC from the executor's nextpc. Runs one instruction at a time until it
// fetches the halt word 32'hFFFF_FFFF.
//
// Sequence per instruction: FETCH (1 + wait cycles), DECODE, EXEC, WB.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   start             restart pulse, honoured only in IDLE or HALT
//   imem_req/addr     fetch request and address (address = pc)
//   imem_ack/rdata    fetch data valid and instruction word
//   exec_en           one-cycle execute strobe
//   pc, nextpc_in     current instruction address, executor's next PC
//   instr_type        decoded type (00=I, 01=R, 10=J); named instr_type
//                     because "type" is a reserved word
//   opc..iindex       registered instruction fields
//   busy, halted      status
//   fault             sticky fetch-timeout flag
//   instr_count       retired-instruction counter (wraps)
//
// Optional build macro SEQ_FETCH_TIMEOUT_EN: enables a fetch-ack watchdog of
// TIMEOUT_CYCLES cycles that sets fault and halts. Without it FETCH waits
// indefinitely and fault is constant 0.
// ---------------------------------------------------------------------------
module exec_sequencer #(
    parameter logic [7:0]  RESET_PC       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        exec_en,
    output logic [7:0]  pc,
    input  logic [7:0]  nextpc_in,
    output logic [1:0]  instr_type,
    output logic [5:0]  opc,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm,
    output logic [25:0] iindex,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    function automatic logic [1:0] decode_type(input logic [5:0] op);
        case (op)
            6'b000000:           return 2'b01;
            6'b000010, 6'b000011: return 2'b10;
            default:             return 2'b00;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [31:0] ir_q, ir_d;      // word captured on fetch ack
    logic [31:0] dec_q, dec_d;    // word behind the field outputs
    logic [1:0]  type_q, type_d;
    logic [15:0] count_q, count_d;

    logic restart;
    logic timeout;

    assign restart = start && (state_q == S_IDLE || state_q == S_HALT);

    always_comb begin
        // NOTE: every _d takes its current value first, so no path through
        // the case leaves it unassigned (an unassigned path infers a latch).
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dec_d   = dec_q;
        type_d  = type_q;
        count_d = count_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (restart) begin
                    pc_d    = RESET_PC;
                    count_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                // The halt word never reaches the field outputs, so they keep
                // showing the last executed instruction while halted.
                if (ir_q == HALT_WORD) begin
                    state_d = S_HALT;
                end else begin
                    dec_d   = ir_q;
                    type_d  = decode_type(ir_q[31:26]);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                pc_d    = nextpc_in;
                count_d = count_q + 16'd1;
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            dec_q   <= '0;
            type_q  <= 2'b00;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dec_q   <= dec_d;
            type_q  <= type_d;
            count_q <= count_d;
        end
    end

`ifdef SEQ_FETCH_TIMEOUT_EN
    logic [7:0] wait_q, wait_d;
    logic       fault_q, fault_d;
    logic       enter_fetch;

    assign enter_fetch = restart || (state_q == S_WB);

    // Fires on the TIMEOUT_CYCLES-th consecutive FETCH cycle without ack.
    assign timeout = (state_q == S_FETCH) && !imem_ack &&
                     (wait_q == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        wait_d  = wait_q;
        fault_d = fault_q;
        if (enter_fetch) begin
            wait_d = '0;
        end else if (state_q == S_FETCH && !imem_ack) begin
            wait_d = wait_q + 8'd1;
        end
        if (restart) begin
            fault_d = 1'b0;
        end else if (timeout) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYCLES only matters with the watchdog built in; folding it into
    // the constant keeps the parameter referenced in this build.
    assign fault   = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign exec_en     = (state_q == S_EXEC);
    assign pc          = pc_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted      = (state_q == S_HALT);
    assign instr_count = count_q;

    assign instr_type  = type_q;
    assign opc         = dec_q[31:26];
    assign rs          = dec_q[25:21];
    assign rt          = dec_q[20:16];
    assign rd          = dec_q[15:11];
    assign shamt       = dec_q[10:6];
    assign funct       = dec_q[5:0];
    assign imm         = dec_q[15:0];
    assign iindex      = dec_q[25:0];

endmodule

// File: tb/tb_exec_sequencer.sv
// ---------------------------------------------------------------------------
// tb_exec_sequencer
//
// Scoreboard bench. A memory responder answers fetches (random or fixed wait
// states) from a program array; every non-halt word it returns is pushed as
// an expected issue. An executor monitor pops one entry per exec_en and
// compares pc and all fields against values derived from the word with plain
// shift/mask arithmetic, then picks the next PC and pushes it as the next
// expected fetch address.
// ---------------------------------------------------------------------------
module tb_exec_sequencer;

    localparam logic [7:0]  RESET_PC  = 8'h00;
    localparam int unsigned TIMEOUT   = 16;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        start      = 1'b0;
    logic        imem_ack   = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [7:0]  nextpc_in  = '0;

    logic        imem_req, exec_en, busy, halted, fault;
    logic [7:0]  imem_addr, pc;
    logic [1:0]  instr_type;
    logic [5:0]  opc, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm, instr_count;
    logic [25:0] iindex;

    exec_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .exec_en(exec_en), .pc(pc), .nextpc_in(nextpc_in),
        .instr_type(instr_type), .opc(opc), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm(imm), .iindex(iindex),
        .busy(busy), .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  addr_q[$];
    logic [7:0]  plan_q[$];
    logic [31:0] mem[256];
    int          model_count  = 0;
    bit          no_ack       = 0;
    bit          late_ack     = 0;
    bit          stop_now     = 0;
    bit          period_valid = 0;
    bit          check_wb     = 0;
    int          fixed_wait   = -1;

    // ---------------- reference helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string detail);
        checks++;
        errors++;
        $display("FAIL %s: %s (t=%0t)", name, detail, $time);
    endtask

    function automatic logic [31:0] fld(input logic [31:0] w, input int lsb, input int width);
        return (w >> lsb) & ((32'd1 << width) - 32'd1);
    endfunction

    function automatic logic [1:0] model_type(input logic [31:0] w);
        logic [31:0] op;
        op = w >> 26;
        if (op == 0) return 2'b01;
        if (op == 2 || op == 3) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 3);
        if (k == 0)      w[31:26] = 6'd0;
        else if (k == 1) w[31:26] = 6'd2;
        else if (k == 2) w[31:26] = 6'd3;
        if (w == HALT_WORD) w = 32'h0;
        return w;
    endfunction

    // ---------------- memory responder (stimulus + expected issues) ----------------
    bit          req_prev    = 0;
    int          wait_left   = 0;
    int          cur_waits   = 0;
    int          fetch_start = 0;
    int          ack_cyc     = 0;
    logic [7:0]  fetch_addr  = '0;
    logic [31:0] rword;
    exp_t        push_e;

    always @(negedge clk) begin
        imem_ack = late_ack;
        if (imem_req) begin
            if (!req_prev) begin
                if (addr_q.size() == 0)
                    fail_now("fetch_unexpected", $sformatf("got fetch at %0h expected none", imem_addr));
                else
                    check("fetch_addr", 32'(imem_addr), 32'(addr_q.pop_front()));
                check("count_at_fetch", 32'(instr_count), 32'(model_count));
                if (period_valid)
                    check("issue_period", 32'(cyc - fetch_start), 32'(cur_waits + 4));
                period_valid = 1;
                fetch_start  = cyc;
                fetch_addr   = imem_addr;
                wait_left    = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
                cur_waits    = wait_left;
            end else begin
                check("fetch_addr_stable", 32'(imem_addr), 32'(fetch_addr));
            end
            if (!no_ack && wait_left == 0) begin
                rword      = stop_now ? HALT_WORD : mem[imem_addr];
                imem_ack   = 1'b1;
                imem_rdata = rword;
                ack_cyc    = cyc;
                if (rword != HALT_WORD) begin
                    push_e.pc   = imem_addr;
                    push_e.word = rword;
                    exp_q.push_back(push_e);
                end
            end else if (wait_left > 0) begin
                wait_left--;
            end
        end
        req_prev = imem_req;
    end

    // ---------------- executor / issue monitor ----------------
    exp_t       e;
    exp_t       last_exp;
    logic [7:0] nxt;

    always @(negedge clk) begin
        if (check_wb) begin
            check_wb = 0;
            check("wb_pc_stable", 32'(pc), 32'(last_exp.pc));
            check("wb_fields_stable", {opc, rs, rt, rd, shamt, funct}, last_exp.word);
            check("wb_type_stable", 32'(instr_type), 32'(model_type(last_exp.word)));
            check("wb_exec_en_low", 32'(exec_en), 32'(0));
        end
        if (exec_en) begin
            if (exp_q.size() == 0) begin
                fail_now("exec_unexpected", $sformatf("got exec_en=1 at pc %0h expected no pending issue", pc));
            end else begin
                e        = exp_q.pop_front();
                last_exp = e;
                check_wb = 1;
                check("exec_pc",      32'(pc),         32'(e.pc));
                check("exec_type",    32'(instr_type), 32'(model_type(e.word)));
                check("exec_opc",     32'(opc),        fld(e.word, 26, 6));
                check("exec_rs",      32'(rs),         fld(e.word, 21, 5));
                check("exec_rt",      32'(rt),         fld(e.word, 16, 5));
                check("exec_rd",      32'(rd),         fld(e.word, 11, 5));
                check("exec_shamt",   32'(shamt),      fld(e.word, 6, 5));
                check("exec_funct",   32'(funct),      fld(e.word, 0, 6));
                check("exec_imm",     32'(imm),        fld(e.word, 0, 16));
                check("exec_iindex",  32'(iindex),     fld(e.word, 0, 26));
                check("exec_latency", 32'(cyc - ack_cyc), 32'(2));
                check("exec_busy",    32'(busy),       32'(1));
                model_count++;
                if (plan_q.size() != 0) nxt = plan_q.pop_front();
                else                    nxt = 8'($urandom);
                nextpc_in = nxt;
                addr_q.push_back(nxt);
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic check_idle(input string tag);
        check({tag, "_busy"},     32'(busy),        32'(0));
        check({tag, "_halted"},   32'(halted),      32'(0));
        check({tag, "_req"},      32'(imem_req),    32'(0));
        check({tag, "_exec_en"},  32'(exec_en),     32'(0));
        check({tag, "_pc"},       32'(pc),          32'(RESET_PC));
        check({tag, "_count"},    32'(instr_count), 32'(0));
        check({tag, "_fault"},    32'(fault),       32'(0));
        check({tag, "_type"},     32'(instr_type),  32'(0));
        check({tag, "_fields"},   {opc, rs, rt, rd, shamt, funct}, 32'(0));
    endtask

    task automatic do_start();
        @(negedge clk);
        exp_q.delete();
        addr_q.delete();
        model_count  = 0;
        period_valid = 0;
        addr_q.push_back(RESET_PC);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_pc",     32'(pc),          32'(RESET_PC));
        check("start_count",  32'(instr_count), 32'(0));
        check("start_busy",   32'(busy),        32'(1));
        check("start_halted", 32'(halted),      32'(0));
        check("start_fault",  32'(fault),       32'(0));
    endtask

    task automatic run_until_halt(input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (!halted) begin
            fail_now("halt_timeout", $sformatf("got halted=0 after %0d cycles expected 1", n));
        end else begin
            check("halt_req",      32'(imem_req),      32'(0));
            check("halt_busy",     32'(busy),          32'(0));
            check("halt_exec_en",  32'(exec_en),       32'(0));
            check("halt_count",    32'(instr_count),   32'(model_count));
            check("halt_exp_left", 32'(exp_q.size()),  32'(0));
            check("halt_addr_left",32'(addr_q.size()), 32'(0));
        end
        plan_q.delete();
    endtask

    task automatic run_program(input int n_instr, input int max_cycles);
        int k = 0;
        while (model_count < n_instr && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        if (model_count < n_instr)
            fail_now("run_timeout", $sformatf("got %0d issues expected %0d", model_count, n_instr));
        stop_now = 1;
        run_until_halt(200);
        stop_now = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 256; i++) mem[i] = rand_word();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int req_cycles;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        #12;
        check_idle("por");
        #10 rst = 1'b1;

        // First instruction: I-type at 0, nextpc 1, halt at 1.
        mem[0] = 32'h2402_0005;
        mem[1] = HALT_WORD;
        fixed_wait = 0;
        plan_q.push_back(8'h01);
        do_start();
        run_until_halt(100);
        check("t1_pc", 32'(pc), 32'(8'h01));
        check("t1_count", 32'(instr_count), 32'(1));

        // R-type then halt; start from HALT must reload pc and clear count.
        mem[0] = 32'h0043_0821;
        mem[1] = HALT_WORD;
        plan_q.push_back(8'h01);
        do_start();
        run_until_halt(100);
        check("t2_held_type",  32'(instr_type), 32'(2'b01));
        check("t2_held_rd",    32'(rd),         32'(1));
        check("t2_held_funct", 32'(funct),      32'(6'h21));

        // Three wait states on every fetch.
        fill_random();
        fixed_wait = 3;
        do_start();
        run_program(6, 300);

        // start pulsed while a fetch is pending must be ignored.
        fill_random();
        fixed_wait = 5;
        plan_q.push_back(8'h40);
        do_start();
        n = 0;
        while (!(model_count >= 1 && imem_req) && n < 200) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fetch_start_count", 32'(instr_count), 32'(1));
        check("fetch_start_addr",  32'(imem_addr),   32'(8'h40));
        check("fetch_start_busy",  32'(busy),        32'(1));
        stop_now = 1;
        run_until_halt(100);
        stop_now = 0;

        // Long random run with random waits, including a pc wrap FF -> 00.
        fill_random();
        fixed_wait = -1;
        plan_q.push_back(8'hFF);
        plan_q.push_back(8'h00);
        do_start();
        run_program(150, 3000);

        // Asynchronous reset in EXEC, then a late ack that must be ignored.
        fill_random();
        do_start();
        n = 0;
        while (!(exec_en && model_count >= 3) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!exec_en) fail_now("reach_exec", "got exec_en=0 expected 1 before reset");
        #1 rst = 1'b0;
        late_ack = 1;
        #1;
        exp_q.delete();
        addr_q.delete();
        plan_q.delete();
        check_wb     = 0;
        model_count  = 0;
        period_valid = 0;
        check_idle("rst_exec");
        @(negedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_busy", 32'(busy),     32'(0));
            check("late_ack_req",  32'(imem_req), 32'(0));
        end
        late_ack = 0;
        do_start();
        run_program(5, 300);

        // Fetch that is never acknowledged.
        no_ack = 1;
        do_start();
`ifdef SEQ_FETCH_TIMEOUT_EN
        req_cycles = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!imem_req) break;
            req_cycles++;
        end
        check("timeout_req_cycles", 32'(req_cycles), 32'(TIMEOUT));
        check("timeout_fault",      32'(fault),      32'(1));
        check("timeout_halted",     32'(halted),     32'(1));
        check("timeout_req",        32'(imem_req),   32'(0));
        no_ack = 0;
        fill_random();
        do_start();
        run_program(3, 200);
        check("timeout_cleared", 32'(fault), 32'(0));
`else
        req_cycles = 0;
        repeat (100) begin
            @(negedge clk);
            if (imem_req) req_cycles++;
        end
        check("noack_req_cycles", 32'(req_cycles), 32'(100));
        check("noack_busy",       32'(busy),       32'(1));
        check("noack_halted",     32'(halted),     32'(0));
        check("noack_fault",      32'(fault),      32'(0));
        check("noack_addr",       32'(imem_addr),  32'(RESET_PC));
        #1 rst = 1'b0;
        no_ack = 0;
        #1;
        exp_q.delete();
        addr_q.delete();
        check_idle("noack_rst");
        @(negedge clk);
        #2 rst = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by t=%0t expected earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
